// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_pkg
//  Description : Shared constants for the multi-port register file:
//                default geometry, the address of R0 and the reset value.
//  Revision    : 1.0  initial release
// ============================================================================
package regfile_pkg;

    localparam int DEFAULT_DATA_W = 16;
    localparam int DEFAULT_ADDR_W = 4;

    // R0 also has a dedicated write port for multi-cycle unit results
    localparam int R0_ADDR = 0;

    localparam logic [DEFAULT_DATA_W-1:0] REG_RESET_VAL = '0;

endpackage
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_scoreboard
//  Description : One pending bit per register. A lock sets the bit and a
//                committed write clears it. When a lock and a write hit the
//                same register in one cycle, the lock wins because it belongs
//                to the younger operation. Two combinational busy lookups.
//                Optional macro: REGFILE_BYPASS_EN makes the lookups report
//                the post-edge state of any register written this cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              lockEn,
    input  logic [ADDR_W-1:0] lockAddr,
    input  logic              clrEn,      // general write after arbitration
    input  logic [ADDR_W-1:0] clrAddr,
    input  logic              clrR0,      // dedicated R0 port write
    input  logic [ADDR_W-1:0] rdAddr1,
    input  logic [ADDR_W-1:0] rdAddr2,
    output logic              busy1,
    output logic              busy2
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0] r_pending;

    // Pending bits: a lock overrides a clear to the same register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (lockEn && (lockAddr == ADDR_W'(i))) begin
                    r_pending[i] <= 1'b1;
                end else if ((clrEn && (clrAddr == ADDR_W'(i))) ||
                             (clrR0 && (i == R0_ADDR))) begin
                    r_pending[i] <= 1'b0;
                end
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic w_wrote1;
    logic w_wrote2;
    logic w_lock1;
    logic w_lock2;

    // Registers being written this cycle report their post-edge pending state
    always_comb begin
        w_wrote1 = !reset && ((clrEn && (clrAddr == rdAddr1)) ||
                              (clrR0 && (rdAddr1 == ADDR_W'(R0_ADDR))));
        w_wrote2 = !reset && ((clrEn && (clrAddr == rdAddr2)) ||
                              (clrR0 && (rdAddr2 == ADDR_W'(R0_ADDR))));
        w_lock1  = !reset && lockEn && (lockAddr == rdAddr1);
        w_lock2  = !reset && lockEn && (lockAddr == rdAddr2);
        busy1    = w_wrote1 ? w_lock1 : r_pending[rdAddr1];
        busy2    = w_wrote2 ? w_lock2 : r_pending[rdAddr2];
    end
`else
    // Busy reflects only the pre-edge pending bits
    always_comb begin
        busy1 = r_pending[rdAddr1];
        busy2 = r_pending[rdAddr2];
    end
`endif

endmodule
`default_nettype wire

// File: rtl/regfile_multiport.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_multiport
//  Description : 2^ADDR_W x DATA_W register file with two asynchronous read
//                ports, one general write port, a dedicated R0 write port and
//                a per-register pending scoreboard for multi-cycle ops.
//                Optional macro: REGFILE_BYPASS_EN forwards data committing
//                this cycle to the read outputs (suppressed during reset).
//  Revision    : 1.0  initial release
// ============================================================================
module regfile_multiport
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              rd_busy1,
    output logic              rd_busy2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              r0_wr_en,
    input  logic [DATA_W-1:0] r0_wr_data,
    output logic [DATA_W-1:0] r0_rd_data,
    input  logic              lock_en,
    input  logic [ADDR_W-1:0] lock_addr
);

    localparam int                DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] C_R0ADDR = ADDR_W'(R0_ADDR);

    logic [DATA_W-1:0] r_regs [DEPTH];
    logic              w_genWrEn;

    // The R0 port beats a general write that also targets R0
    always_comb begin
        w_genWrEn = wr_en && !(r0_wr_en && (wr_addr == C_R0ADDR));
    end

    // Data array update; reset clears everything and ignores writes
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= DATA_W'(REG_RESET_VAL);
            end
        end else begin
            if (w_genWrEn) begin
                r_regs[wr_addr] <= wr_data;
            end
            if (r0_wr_en) begin
                r_regs[C_R0ADDR] <= r0_wr_data;
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    // Forward the value about to commit; the R0 port takes priority at R0
    always_comb begin
        rd_data1   = r_regs[rd_addr1];
        rd_data2   = r_regs[rd_addr2];
        r0_rd_data = r_regs[C_R0ADDR];
        if (!reset) begin
            if (r0_wr_en && (rd_addr1 == C_R0ADDR)) begin
                rd_data1 = r0_wr_data;
            end else if (w_genWrEn && (rd_addr1 == wr_addr)) begin
                rd_data1 = wr_data;
            end
            if (r0_wr_en && (rd_addr2 == C_R0ADDR)) begin
                rd_data2 = r0_wr_data;
            end else if (w_genWrEn && (rd_addr2 == wr_addr)) begin
                rd_data2 = wr_data;
            end
            if (r0_wr_en) begin
                r0_rd_data = r0_wr_data;
            end else if (w_genWrEn && (wr_addr == C_R0ADDR)) begin
                r0_rd_data = wr_data;
            end
        end
    end
`else
    // Plain asynchronous reads of pre-edge contents
    always_comb begin
        rd_data1   = r_regs[rd_addr1];
        rd_data2   = r_regs[rd_addr2];
        r0_rd_data = r_regs[C_R0ADDR];
    end
`endif

    regfile_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .lockEn   (lock_en),
        .lockAddr (lock_addr),
        .clrEn    (w_genWrEn),
        .clrAddr  (wr_addr),
        .clrR0    (r0_wr_en),
        .rdAddr1  (rd_addr1),
        .rdAddr2  (rd_addr2),
        .busy1    (rd_busy1),
        .busy2    (rd_busy2)
    );

endmodule
`default_nettype wire

// File: tb/tb_regfile_multiport.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_multiport
//  Description : Self-checking bench for regfile_multiport. Stimulus pushes
//                the expected read-side outputs into a queue; a monitor pops
//                and compares at the falling edge. The reference model is a
//                plain array of register values and pending flags.
//                Optional macro: REGFILE_BYPASS_EN (must match the RTL build).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_regfile_multiport;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  rd_addr1, rd_addr2, wr_addr, lock_addr;
    logic [15:0] rd_data1, rd_data2, wr_data, r0_wr_data, r0_rd_data;
    logic        rd_busy1, rd_busy2, wr_en, r0_wr_en, lock_en;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  a1;
        logic [3:0]  a2;
        logic [15:0] d1;
        logic [15:0] d2;
        logic [15:0] r0;
        logic        b1;
        logic        b2;
    } exp_t;

    exp_t expQ[$];

    logic [15:0] mRegs [16];
    bit          mPend [16];

    regfile_multiport #(
        .DATA_W (16),
        .ADDR_W (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rd_addr1   (rd_addr1),
        .rd_addr2   (rd_addr2),
        .rd_data1   (rd_data1),
        .rd_data2   (rd_data2),
        .rd_busy1   (rd_busy1),
        .rd_busy2   (rd_busy2),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .r0_wr_en   (r0_wr_en),
        .r0_wr_data (r0_wr_data),
        .r0_rd_data (r0_rd_data),
        .lock_en    (lock_en),
        .lock_addr  (lock_addr)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: outputs are stable mid-cycle, compare against the oldest expectation
    initial begin
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                exp_t e;
                e = expQ.pop_front();
                cmp($sformatf("rd_data1[a=%0d]", e.a1), rd_data1, e.d1);
                cmp($sformatf("rd_data2[a=%0d]", e.a2), rd_data2, e.d2);
                cmp("r0_rd_data", r0_rd_data, e.r0);
                cmp($sformatf("rd_busy1[a=%0d]", e.a1), {15'd0, rd_busy1}, {15'd0, e.b1});
                cmp($sformatf("rd_busy2[a=%0d]", e.a2), {15'd0, rd_busy2}, {15'd0, e.b2});
            end
        end
    end

    // One clock of stimulus: compute the next model state, predict outputs, commit
    task automatic step(input bit rst, input bit chk,
                        input bit we, input logic [3:0] wa, input logic [15:0] wd,
                        input bit r0we, input logic [15:0] r0wd,
                        input bit lk, input logic [3:0] la,
                        input logic [3:0] a1, input logic [3:0] a2);
        logic [15:0] nRegs [16];
        bit          nPend [16];
`ifdef REGFILE_BYPASS_EN
        bit          wrote [16];
`endif
        exp_t        e;
        reset = rst; wr_en = we; wr_addr = wa; wr_data = wd;
        r0_wr_en = r0we; r0_wr_data = r0wd; lock_en = lk; lock_addr = la;
        rd_addr1 = a1; rd_addr2 = a2;

        for (int i = 0; i < 16; i++) begin
            nRegs[i] = mRegs[i];
            nPend[i] = mPend[i];
`ifdef REGFILE_BYPASS_EN
            wrote[i] = 1'b0;
`endif
        end
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                nRegs[i] = 16'h0000;
                nPend[i] = 1'b0;
            end
        end else begin
            if (we && !(r0we && wa == 4'd0)) begin
                nRegs[wa] = wd;
                nPend[wa] = 1'b0;
`ifdef REGFILE_BYPASS_EN
                wrote[wa] = 1'b1;
`endif
            end
            if (r0we) begin
                nRegs[0] = r0wd;
                nPend[0] = 1'b0;
`ifdef REGFILE_BYPASS_EN
                wrote[0] = 1'b1;
`endif
            end
            if (lk) nPend[la] = 1'b1;
        end

        if (chk) begin
            e.a1 = a1;
            e.a2 = a2;
`ifdef REGFILE_BYPASS_EN
            e.d1 = wrote[a1] ? nRegs[a1] : mRegs[a1];
            e.d2 = wrote[a2] ? nRegs[a2] : mRegs[a2];
            e.r0 = wrote[0]  ? nRegs[0]  : mRegs[0];
            e.b1 = wrote[a1] ? nPend[a1] : mPend[a1];
            e.b2 = wrote[a2] ? nPend[a2] : mPend[a2];
`else
            e.d1 = mRegs[a1];
            e.d2 = mRegs[a2];
            e.r0 = mRegs[0];
            e.b1 = mPend[a1];
            e.b2 = mPend[a2];
`endif
            expQ.push_back(e);
        end

        @(posedge clk);
        for (int i = 0; i < 16; i++) begin
            mRegs[i] = nRegs[i];
            mPend[i] = nPend[i];
        end
        #1;
    endtask

    task automatic idle(input logic [3:0] a1, input logic [3:0] a2);
        step(0, 1, 0, 4'd0, 16'h0, 0, 16'h0, 0, 4'd0, a1, a2);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            mRegs[i] = 16'h0000;
            mPend[i] = 1'b0;
        end
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        r0_wr_en = 1'b0; r0_wr_data = '0; lock_en = 1'b0; lock_addr = '0;
        rd_addr1 = '0; rd_addr2 = '0;
        @(posedge clk); #1;

        // Reset with stray write/lock attempts that must be ignored
        step(1, 0, 1, 4'd6, 16'hDEAD, 1, 16'hBEEF, 1, 4'd6, 4'd0, 4'd0);

        // Every address reads zero and not busy after reset
        for (int i = 0; i < 16; i++) idle(4'(i), 4'(15 - i));

        // General write then read-back; neighbour untouched
        step(0, 1, 1, 4'd3, 16'h4020, 0, 16'h0, 0, 4'd0, 4'd3, 4'd4);
        idle(4'd3, 4'd4);

        // R0 port wins the conflict with a general write to R0
        step(0, 1, 1, 4'd0, 16'h4020, 1, 16'h1239, 0, 4'd0, 4'd0, 4'd3);
        idle(4'd0, 4'd3);

        // Lock, clear by write, then same-cycle lock+write keeps pending
        step(0, 1, 0, 4'd0, 16'h0, 0, 16'h0, 1, 4'd5, 4'd5, 4'd0);
        idle(4'd5, 4'd0);
        step(0, 1, 1, 4'd5, 16'hBEEF, 0, 16'h0, 0, 4'd0, 4'd5, 4'd5);
        idle(4'd5, 4'd0);
        step(0, 1, 1, 4'd5, 16'h1111, 0, 16'h0, 1, 4'd5, 4'd5, 4'd5);
        idle(4'd5, 4'd5);
        // Re-locking an already pending register
        step(0, 1, 0, 4'd0, 16'h0, 0, 16'h0, 1, 4'd5, 4'd5, 4'd5);
        // R0 port clears an R0 lock
        step(0, 1, 0, 4'd0, 16'h0, 0, 16'h0, 1, 4'd0, 4'd0, 4'd5);
        step(0, 1, 0, 4'd0, 16'h0, 1, 16'h7777, 0, 4'd0, 4'd0, 4'd0);
        idle(4'd0, 4'd5);

        // Same-cycle read of a register being written
        step(0, 1, 1, 4'd7, 16'h1234, 0, 16'h0, 0, 4'd0, 4'd3, 4'd7);
        idle(4'd3, 4'd7);

        // Reset mid-operation discards locks and data
        step(0, 1, 0, 4'd0, 16'h0, 0, 16'h0, 1, 4'd2, 4'd9, 4'd2);
        step(0, 1, 1, 4'd9, 16'h00FF, 0, 16'h0, 0, 4'd0, 4'd9, 4'd2);
        step(1, 1, 1, 4'd9, 16'h5555, 1, 16'h6666, 1, 4'd9, 4'd9, 4'd2);
        idle(4'd9, 4'd2);
        step(0, 1, 1, 4'd9, 16'hABCD, 0, 16'h0, 0, 4'd0, 4'd9, 4'd2);
        idle(4'd9, 4'd0);

        // Randomized traffic against the model
        for (int n = 0; n < 2000; n++) begin
            step(($urandom % 64) == 0, 1,
                 1'($urandom), 4'($urandom), 16'($urandom),
                 ($urandom % 4) == 0, 16'($urandom),
                 ($urandom % 3) == 0, 4'($urandom),
                 4'($urandom), 4'($urandom));
        end

        repeat (3) @(posedge clk);
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", expQ.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
